// File: rtl/tc_timer_pkg.sv
// tc_timer_pkg: shared constants and types for the memory-mapped countdown timer.
//   - register word offsets (addr[3:2] of the byte address)
//   - CTRL bit positions and mode codes
//   - FSM state encoding (also exported on the debug port)
package tc_timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage

// File: rtl/tc_timer.sv
// tc_timer: countdown timer with one-shot and auto-reload modes.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   addr[1:0]  in   word offset: 0=CTRL, 1=PRESET, 2=COUNT (read-only), 3=reserved
//   we         in   write strobe
//   byteen[3:0]in   byte enables; only full-word writes (4'b1111) are accepted
//   din[31:0]  in   write data
//   dout[31:0] out  read data, combinational from addr (reserved reads 0)
//   irq        out  registered interrupt request = ctrl.im & irq_flag
//   state_dbg  out  current FSM state
//
// Bus handshake: there is no back-pressure. A write is a single-cycle strobe
// (we high with byteen==4'b1111) committed at the rising edge; reads are
// combinational and always valid.
module tc_timer
  import tc_timer_pkg::*;
#(
  parameter int          WIDTH          = 32,
  parameter logic [31:0] PRESET_DEFAULT = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq,
  output state_t      state_dbg
);

  state_t            state, state_nx;
  logic [3:0]        ctrl, ctrl_nx;
  logic [WIDTH-1:0]  preset, preset_nx;
  logic [WIDTH-1:0]  count, count_nx;
  logic              irq_flag, irq_flag_nx;

  logic wr_ok, wr_ctrl, wr_preset;
  logic en, reload;
  logic fsm_en_clr, fsm_flag_set, fsm_flag_clr;

  assign wr_ok     = we && (byteen == 4'b1111);
  assign wr_ctrl   = wr_ok && (addr == ADDR_CTRL);
  assign wr_preset = wr_ok && (addr == ADDR_PRESET);

  assign en     = ctrl[CTRL_EN];
  // Mode codes 1x fall back to one-shot.
  assign reload = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

  assign state_dbg = state;

  // Next-state / datapath control.
  always_comb begin
    state_nx     = state;
    count_nx     = count;
    fsm_en_clr   = 1'b0;
    fsm_flag_set = 1'b0;
    fsm_flag_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        count_nx = preset;
        state_nx = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_nx = ST_IDLE;
        end else if (count <= WIDTH'(1)) begin
          // PRESET=0 lands here on the first CNT cycle, so it acts like 1.
          count_nx     = '0;
          fsm_flag_set = 1'b1;
          state_nx     = ST_INT;
        end else begin
          count_nx = count - WIDTH'(1);
        end
      end
      ST_INT: begin
        if (reload) fsm_flag_clr = 1'b1;
        else        fsm_en_clr   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Register file updates.
  always_comb begin
    ctrl_nx   = ctrl;
    preset_nx = preset;
    // The bus write wins over the FSM clearing en in the same cycle.
    if (wr_ctrl)         ctrl_nx = din[3:0];
    else if (fsm_en_clr) ctrl_nx[CTRL_EN] = 1'b0;

    if (wr_preset) preset_nx = din[WIDTH-1:0];

    // The flag is acknowledged by a PRESET write or by a CTRL write that
    // (re)launches the timer. CTRL writes with en=0 only change the mask,
    // so a pending interrupt survives masking and reappears on unmasking.
    // An expiry in the same cycle as any clear keeps the flag set.
    irq_flag_nx = irq_flag;
    if (fsm_flag_set)
      irq_flag_nx = 1'b1;
    else if (fsm_flag_clr || wr_preset || (wr_ctrl && din[CTRL_EN]))
      irq_flag_nx = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= 4'd0;
      preset   <= PRESET_DEFAULT[WIDTH-1:0];
      count    <= '0;
      irq_flag <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state    <= state_nx;
      ctrl     <= ctrl_nx;
      preset   <= preset_nx;
      count    <= count_nx;
      irq_flag <= irq_flag_nx;
      // Registered from next-state values so irq tracks im & irq_flag
      // without an extra cycle of delay.
      irq      <= ctrl_nx[CTRL_IM] & irq_flag_nx;
    end
  end

  // Read mux; narrower registers zero-extend.
  always_comb begin
    dout = 32'd0;
    case (addr)
      ADDR_CTRL:   dout[3:0]       = ctrl;
      ADDR_PRESET: dout[WIDTH-1:0] = preset;
      ADDR_COUNT:  dout[WIDTH-1:0] = count;
      default:     dout            = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_tc_timer.sv
module tb_tc_timer;
  import tc_timer_pkg::*;

  localparam logic [31:0] PDEF = 32'd17;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [3:0]  byteen = 4'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        irq;
  state_t      state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  tc_timer #(.WIDTH(32), .PRESET_DEFAULT(PDEF)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .byteen(byteen),
    .din(din), .dout(dout), .irq(irq), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Drives a write that commits at the next rising edge; returns 1ns after it.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; din = d; byteen = be; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; byteen = 4'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = dout;
  endtask

  // Advance one edge and land at the sampling point (falling edge).
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  task automatic expect_val(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: got %h want <no expectation queued>", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", name, act, e);
      end
    end
  endtask

  task automatic chk_irq(input string name, input logic e);
    expect_val({31'd0, e});
    check(name, {31'd0, irq});
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] e);
    logic [31:0] v;
    expect_val(e);
    rd(a, v);
    check(name, v);
  endtask

  // ---------------- table-driven register vectors ----------------
  typedef struct {
    bit          is_wr;
    logic [1:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [31:0] v;
    int n, eff;
    bit found;

    vecs[0]  = '{0, ADDR_CTRL,   4'hF, 32'h0,         32'h0};
    vecs[1]  = '{0, ADDR_PRESET, 4'hF, 32'h0,         PDEF};
    vecs[2]  = '{0, ADDR_COUNT,  4'hF, 32'h0,         32'h0};
    vecs[3]  = '{0, 2'd3,        4'hF, 32'h0,         32'h0};
    vecs[4]  = '{1, ADDR_PRESET, 4'hF, 32'h1234_5678, 32'h0};
    vecs[5]  = '{0, ADDR_PRESET, 4'hF, 32'h0,         32'h1234_5678};
    vecs[6]  = '{1, ADDR_PRESET, 4'h3, 32'h0000_DEAD, 32'h0};
    vecs[7]  = '{0, ADDR_PRESET, 4'hF, 32'h0,         32'h1234_5678};
    vecs[8]  = '{1, ADDR_CTRL,   4'hF, 32'hFFFF_FFFE, 32'h0};
    vecs[9]  = '{0, ADDR_CTRL,   4'hF, 32'h0,         32'h0000_000E};
    vecs[10] = '{1, ADDR_CTRL,   4'hF, 32'h0,         32'h0};
    vecs[11] = '{0, ADDR_CTRL,   4'hF, 32'h0,         32'h0};
    vecs[12] = '{1, ADDR_COUNT,  4'hF, 32'h55,        32'h0};
    vecs[13] = '{0, ADDR_COUNT,  4'hF, 32'h0,         32'h0};
    vecs[14] = '{1, 2'd3,        4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[15] = '{0, 2'd3,        4'hF, 32'h0,         32'h0};
    vecs[16] = '{1, ADDR_CTRL,   4'hE, 32'h5,         32'h0};
    vecs[17] = '{0, ADDR_CTRL,   4'hF, 32'h0,         32'h0};

    // ---- reset ----
    do_reset();
    @(negedge clk);
    chk_irq("reset_irq", 1'b0);
    expect_val({30'd0, ST_IDLE});
    check("reset_state", {30'd0, state_dbg});

    // ---- register access table (timer stays idle: en never set) ----
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].a, vecs[i].d, vecs[i].be);
      end else begin
        expect_val(vecs[i].exp);
        rd(vecs[i].a, v);
        check($sformatf("regvec%0d", i), v);
      end
    end
    chk_irq("regvec_irq", 1'b0);

    // ---- one-shot, PRESET=5 ----
    do_reset();
    bus_write(ADDR_PRESET, 32'd5, 4'hF);
    bus_write(ADDR_CTRL, 32'h9, 4'hF);          // edge E0
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_irq($sformatf("oneshot_irq_e%0d", k), k == 7);
      if (k >= 2) chk_reg($sformatf("oneshot_count_e%0d", k), ADDR_COUNT, 32'(7 - k));
    end
    tick();
    chk_reg("oneshot_en_cleared", ADDR_CTRL, 32'h8);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_irq("oneshot_irq_hold", 1'b1);
    end
    bus_write(ADDR_CTRL, 32'h0, 4'hF);
    @(negedge clk);
    chk_irq("oneshot_irq_cleared", 1'b0);

    // ---- one-shot latency sweep incl. PRESET=0 and random presets ----
    for (int r = 0; r < 5; r++) begin
      n = (r < 2) ? r : int'($urandom_range(2, 12));
      eff = (n == 0) ? 1 : n;
      do_reset();
      bus_write(ADDR_PRESET, 32'(n), 4'hF);
      bus_write(ADDR_CTRL, 32'h9, 4'hF);
      for (int k = 1; k <= eff + 2; k++) begin
        tick();
        chk_irq($sformatf("sweep_n%0d_e%0d", n, k), k == eff + 2);
      end
    end

    // ---- auto-reload, PRESET=3: pulse every 6 cycles ----
    do_reset();
    bus_write(ADDR_PRESET, 32'd3, 4'hF);
    bus_write(ADDR_CTRL, 32'hB, 4'hF);
    for (int k = 1; k <= 26; k++) begin
      tick();
      chk_irq($sformatf("reload_irq_e%0d", k), (k >= 5) && ((k - 5) % 6 == 0));
      chk_reg($sformatf("reload_en_e%0d", k), ADDR_CTRL, 32'hB);
    end

    // ---- enable drop at COUNT=6 ----
    do_reset();
    bus_write(ADDR_PRESET, 32'd10, 4'hF);
    bus_write(ADDR_CTRL, 32'h9, 4'hF);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      rd(ADDR_COUNT, v);
      if (v == 32'd7) found = 1'b1;
    end
    expect_val(32'd1);
    check("drop_count_reached_7", {31'd0, found});
    // Commits on the same edge the count steps 7 -> 6.
    bus_write(ADDR_CTRL, 32'h0, 4'hF);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk_irq("drop_no_irq", 1'b0);
      if (k % 5 == 4) chk_reg("drop_count_hold", ADDR_COUNT, 32'd6);
      @(posedge clk);
    end

    // ---- collision: expiry edge with a PRESET write ----
    do_reset();
    bus_write(ADDR_PRESET, 32'd4, 4'hF);
    bus_write(ADDR_CTRL, 32'h9, 4'hF);          // E0, expiry at E0+6
    for (int k = 1; k <= 5; k++) tick();
    chk_irq("collide_before", 1'b0);
    bus_write(ADDR_PRESET, 32'd7, 4'hF);        // E0+6
    @(negedge clk);
    chk_irq("collide_set_wins", 1'b1);
    tick();
    chk_irq("collide_flag_kept", 1'b1);
    chk_reg("collide_preset", ADDR_PRESET, 32'd7);
    bus_write(ADDR_PRESET, 32'd7, 4'hF);
    @(negedge clk);
    chk_irq("collide_later_clear", 1'b0);

    // ---- masking ----
    do_reset();
    bus_write(ADDR_PRESET, 32'd2, 4'hF);
    bus_write(ADDR_CTRL, 32'h1, 4'hF);          // im=0, expiry at E0+4
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_irq("mask_irq_low", 1'b0);
    end
    bus_write(ADDR_CTRL, 32'h8, 4'hF);
    @(negedge clk);
    chk_irq("mask_unmask_irq", 1'b1);
    bus_write(ADDR_CTRL, 32'h0, 4'hF);
    @(negedge clk);
    chk_irq("mask_remask_irq", 1'b0);
    bus_write(ADDR_CTRL, 32'h8, 4'hF);
    @(negedge clk);
    chk_irq("mask_flag_kept", 1'b1);
    bus_write(ADDR_PRESET, 32'd2, 4'h3);        // partial write: ignored
    @(negedge clk);
    chk_irq("mask_partial_no_clear", 1'b1);
    bus_write(ADDR_PRESET, 32'd2, 4'hF);
    @(negedge clk);
    chk_irq("mask_preset_clear", 1'b0);

    // ---- reset mid-run ----
    bus_write(ADDR_PRESET, 32'd8, 4'hF);
    bus_write(ADDR_CTRL, 32'h9, 4'hF);
    for (int k = 0; k < 4; k++) tick();
    do_reset();
    @(negedge clk);
    chk_reg("midreset_count", ADDR_COUNT, 32'd0);
    chk_reg("midreset_ctrl", ADDR_CTRL, 32'd0);
    chk_reg("midreset_preset", ADDR_PRESET, PDEF);
    chk_irq("midreset_irq", 1'b0);
    expect_val({30'd0, ST_IDLE});
    check("midreset_state", {30'd0, state_dbg});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
